rf_multi_writeback: RTL and testbench



---
 rtl/rf_multi_writeback_pkg.sv | 21 ++
 rtl/rf_multi_writeback_lowest_set_bit.sv | 21 ++
 rtl/rf_multi_writeback.sv | 116 +++++++++++
 tb/tb_rf_multi_writeback.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rf_multi_writeback_pkg.sv
// Shared types and constants for the register-file multi-writeback initiator.
package rf_multi_writeback_pkg;

   typedef enum logic {IDLE, WRITE} state_t;

   localparam int         DW     = 32;
   localparam int         NREG   = 16;
   localparam int         IDX_W  = 4;
   localparam logic [3:0] REG_PC = 4'd15;

   // Number of set bits in a register list; 5 bits so a full list reads as 16.
   function automatic logic [4:0] popcount(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) begin
         n = n + {4'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/rf_multi_writeback_lowest_set_bit.sv
// Combinational 16-to-4 priority encoder: index of the lowest set bit plus a found flag.
module lowest_set_bit
   import rf_multi_writeback_pkg::*;
(
   input  logic [NREG-1:0]  vec,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   always_comb begin
      idx   = '0;
      found = |vec;
      // Scan downward so the lowest set bit is the last one assigned.
      for (int i = NREG - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/rf_multi_writeback.sv
// Writeback-stage initiator: turns a register list plus a data stream into one
// register-file write per accepted word, in ascending register order.
module rf_multi_writeback #(
   parameter int DW   = 32,
   parameter int NREG = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            START,
   input  logic [NREG-1:0] REGLIST,
   input  logic [DW-1:0]   DIN,
   input  logic            DIN_VALID,
   output logic            DIN_READY,
   output logic [3:0]      C,
   output logic [DW-1:0]   PW,
   output logic            RFLd,
   output logic            PCLd,
   output logic            BUSY,
   output logic            DONE,
   output logic [4:0]      REMAIN
);
   import rf_multi_writeback_pkg::*;

   state_t          state_q, state_d;
   logic [NREG-1:0] pend_q, pend_d;
   logic [3:0]      c_q, c_d;
   logic [DW-1:0]   pw_q, pw_d;
   logic            rfld_q, rfld_d;
   logic            pcld_q, pcld_d;
   logic            done_q, done_d;
   logic [4:0]      remain_q, remain_d;

   logic [3:0]      target;
   logic            found;
   logic            hs;

   lowest_set_bit u_lsb (
      .vec   (pend_q),
      .idx   (target),
      .found (found)
   );

   assign DIN_READY = (state_q == WRITE);
   assign hs        = DIN_VALID & DIN_READY & found;

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      c_d      = c_q;
      pw_d     = pw_q;
      rfld_d   = 1'b0;
      pcld_d   = 1'b0;
      done_d   = 1'b0;
      remain_d = remain_q;
      unique case (state_q)
         IDLE: begin
            if (START) begin
               if (REGLIST != '0) begin
                  pend_d   = REGLIST;
                  remain_d = popcount(REGLIST);
                  state_d  = WRITE;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         WRITE: begin
            if (hs) begin
               c_d            = target;
               pw_d           = DIN;
               rfld_d         = 1'b1;
               pcld_d         = (target == REG_PC);
               pend_d[target] = 1'b0;
               remain_d       = remain_q - 5'd1;
               // Last pending register: finish on the same edge as its write.
               if (remain_q == 5'd1) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         pend_q   <= '0;
         c_q      <= '0;
         pw_q     <= '0;
         rfld_q   <= 1'b0;
         pcld_q   <= 1'b0;
         done_q   <= 1'b0;
         remain_q <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         c_q      <= c_d;
         pw_q     <= pw_d;
         rfld_q   <= rfld_d;
         pcld_q   <= pcld_d;
         done_q   <= done_d;
         remain_q <= remain_d;
      end
   end

   assign C      = c_q;
   assign PW     = pw_q;
   assign RFLd   = rfld_q;
   assign PCLd   = pcld_q;
   assign DONE   = done_q;
   assign REMAIN = remain_q;
   assign BUSY   = (state_q == WRITE);

endmodule

// File: tb/tb_rf_multi_writeback.sv
// Bench for rf_multi_writeback: queue-based reference model, directed scenarios
// with literal expectations, then randomized traffic.
module tb_rf_multi_writeback;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic [15:0] REGLIST;
   logic [31:0] DIN;
   logic        DIN_VALID;
   logic        DIN_READY;
   logic [3:0]  C;
   logic [31:0] PW;
   logic        RFLd;
   logic        PCLd;
   logic        BUSY;
   logic        DONE;
   logic [4:0]  REMAIN;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a queue of register indices still to be written.
   int          m_q[$];
   bit          m_busy;
   logic [3:0]  m_c;
   logic [31:0] m_pw;
   bit          m_rfld, m_pcld, m_done;

   rf_multi_writeback #(.DW(32), .NREG(16)) dut (
      .CLK(CLK), .RST(RST), .START(START), .REGLIST(REGLIST),
      .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
      .C(C), .PW(PW), .RFLd(RFLd), .PCLd(PCLd),
      .BUSY(BUSY), .DONE(DONE), .REMAIN(REMAIN)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (RST) begin
         m_q.delete();
         m_busy = 0; m_c = '0; m_pw = '0;
         m_rfld = 0; m_pcld = 0; m_done = 0;
      end else begin
         m_rfld = 0; m_pcld = 0; m_done = 0;
         if (!m_busy) begin
            if (START) begin
               if (REGLIST == 16'h0) m_done = 1;
               else begin
                  for (int i = 0; i < 16; i++) if (REGLIST[i]) m_q.push_back(i);
                  m_busy = 1;
               end
            end
         end else if (DIN_VALID) begin
            int t;
            t = m_q.pop_front();
            m_c = 4'(t); m_pw = DIN; m_rfld = 1; m_pcld = (t == 15);
            if (m_q.size() == 0) begin
               m_done = 1; m_busy = 0;
            end
         end
      end
   endtask

   task automatic compare();
      chk("BUSY", {31'd0, BUSY}, {31'd0, m_busy});
      chk("DIN_READY", {31'd0, DIN_READY}, {31'd0, m_busy});
      chk("RFLd", {31'd0, RFLd}, {31'd0, m_rfld});
      chk("PCLd", {31'd0, PCLd}, {31'd0, m_pcld});
      chk("DONE", {31'd0, DONE}, {31'd0, m_done});
      chk("C", {28'd0, C}, {28'd0, m_c});
      chk("PW", PW, m_pw);
      chk("REMAIN", {27'd0, REMAIN}, 32'(m_q.size()));
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
      compare();
   endtask

   task automatic idle_inputs();
      RST = 0; START = 0; REGLIST = '0; DIN_VALID = 0; DIN = '0;
   endtask

   initial begin
      int pulses;
      int dones;
      logic [31:0] pat;
      idle_inputs();
      RST = 1;
      step(); step();
      chk("reset_C_lit", {28'd0, C}, 32'd0);
      chk("reset_REMAIN_lit", {27'd0, REMAIN}, 32'd0);
      idle_inputs();

      // 0x0005 back-to-back
      START = 1; REGLIST = 16'h0005; step();
      START = 0; DIN_VALID = 1; DIN = 32'h11; step();
      chk("s1_w0_C", {28'd0, C}, 32'd0);
      chk("s1_w0_PW", PW, 32'h11);
      chk("s1_w0_REMAIN", {27'd0, REMAIN}, 32'd1);
      DIN = 32'h22; step();
      chk("s1_w1_C", {28'd0, C}, 32'd2);
      chk("s1_w1_PW", PW, 32'h22);
      chk("s1_w1_DONE", {31'd0, DONE}, 32'd1);
      chk("s1_w1_RFLd", {31'd0, RFLd}, 32'd1);
      chk("s1_w1_REMAIN", {27'd0, REMAIN}, 32'd0);
      idle_inputs(); step();

      // 0x8001: second write targets the PC
      START = 1; REGLIST = 16'h8001; step();
      START = 0; DIN_VALID = 1; DIN = 32'hA; step();
      chk("s2_w0_PCLd", {31'd0, PCLd}, 32'd0);
      DIN = 32'h100; step();
      chk("s2_w1_C", {28'd0, C}, 32'd15);
      chk("s2_w1_PW", PW, 32'h100);
      chk("s2_w1_PCLd", {31'd0, PCLd}, 32'd1);
      idle_inputs(); step();

      // 0x00F0 with gapped DIN_VALID
      START = 1; REGLIST = 16'h00F0; step();
      START = 0; pat = 32'b1011001; pulses = 0;
      for (int i = 0; i < 7; i++) begin
         DIN_VALID = pat[6 - i]; DIN = 32'h300 + 32'(i); step();
         if (RFLd) begin
            chk("s3_C_seq", {28'd0, C}, 32'd4 + 32'(pulses));
            pulses++;
         end
      end
      chk("s3_pulses", 32'(pulses), 32'd4);
      idle_inputs(); step();

      // START while busy is ignored
      START = 1; REGLIST = 16'h0003; step();
      REGLIST = 16'h0002; DIN_VALID = 1; DIN = 32'h55; dones = 0; pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         START = 0;
         if (DONE) dones++;
         if (RFLd) pulses++;
      end
      chk("s4_dones", 32'(dones), 32'd1);
      chk("s4_writes", 32'(pulses), 32'd2);
      idle_inputs(); step();

      // RST mid-sequence
      START = 1; REGLIST = 16'h0007; step();
      START = 0; DIN_VALID = 1; DIN = 32'h77; step();
      RST = 1; step();
      chk("s5_RFLd", {31'd0, RFLd}, 32'd0);
      chk("s5_BUSY", {31'd0, BUSY}, 32'd0);
      chk("s5_REMAIN", {27'd0, REMAIN}, 32'd0);
      RST = 0; dones = 0;
      for (int i = 0; i < 4; i++) begin step(); if (DONE) dones++; end
      chk("s5_no_done", 32'(dones), 32'd0);
      idle_inputs();

      // Empty list
      START = 1; REGLIST = 16'h0000; step();
      chk("s6_DONE", {31'd0, DONE}, 32'd1);
      chk("s6_BUSY", {31'd0, BUSY}, 32'd0);
      START = 0; step();
      chk("s6_DONE_once", {31'd0, DONE}, 32'd0);

      // Randomized traffic
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int r;
         RST = ($urandom_range(0, 199) == 0);
         START = ($urandom_range(0, 3) == 0);
         r = $urandom_range(0, 9);
         if (r == 0) REGLIST = 16'h0000;
         else if (r == 1) REGLIST = 16'hFFFF;
         else REGLIST = 16'($urandom);
         DIN_VALID = ($urandom_range(0, 3) != 0);
         DIN = $urandom;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
